// File: rtl/beta_mem_arbiter.sv
// Shared memory port arbiter between instruction fetch and the LSU.
// LSU has fixed priority; a starvation counter bounds how long fetch can wait.
module beta_mem_arbiter #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxStarve = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     if_req_i,
   input  logic [AddrWidth-1:0]     if_addr_i,
   output logic                     if_gnt_o,
   output logic                     if_rvalid_o,
   output logic [DataWidth-1:0]     if_rdata_o,
   input  logic                     lsu_req_i,
   input  logic                     lsu_we_i,
   input  logic [DataWidth/8-1:0]   lsu_be_i,
   input  logic [AddrWidth-1:0]     lsu_addr_i,
   input  logic [DataWidth-1:0]     lsu_wdata_i,
   output logic                     lsu_gnt_o,
   output logic                     lsu_rvalid_o,
   output logic [DataWidth-1:0]     lsu_rdata_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [DataWidth/8-1:0]   mem_be_o,
   output logic [AddrWidth-1:0]     mem_addr_o,
   output logic [DataWidth-1:0]     mem_wdata_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [DataWidth-1:0]     mem_rdata_i,
   output logic                     arb_busy_o,
   output logic                     arb_owner_o
);

   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned CntWidth = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_e;

   state_e                 state_q, state_d;
   logic                   owner_q, owner_d;
   logic [CntWidth-1:0]    starve_q, starve_d;
   logic                   we_q, we_d;
   logic [BeWidth-1:0]     be_q, be_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;

   logic                   fetch_starved;
   logic                   lsu_win;
   logic                   if_win;

   // Fetch overrides LSU priority once it has lost MaxStarve captures in a row.
   always_comb begin
      fetch_starved = if_req_i && (starve_q == CntWidth'(MaxStarve));
      lsu_win       = lsu_req_i && !fetch_starved;
      if_win        = if_req_i && !lsu_win;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         starve_q <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      starve_d  = starve_q;
      we_d      = we_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      if_gnt_o  = 1'b0;
      lsu_gnt_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Grants are suppressed while reset is held so nothing leaks out.
            if (!rst_i) begin
               if (lsu_win) begin
                  lsu_gnt_o = 1'b1;
                  owner_d   = 1'b1;
                  we_d      = lsu_we_i;
                  be_d      = lsu_be_i;
                  addr_d    = lsu_addr_i;
                  wdata_d   = lsu_wdata_i;
                  starve_d  = if_req_i ? (starve_q + CntWidth'(1)) : '0;
                  state_d   = ST_REQ;
               end else if (if_win) begin
                  if_gnt_o  = 1'b1;
                  owner_d   = 1'b0;
                  we_d      = 1'b0;
                  be_d      = '1;
                  addr_d    = if_addr_i;
                  wdata_d   = '0;
                  starve_d  = '0;
                  state_d   = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_gnt_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Responses only count while a transaction is waiting for one.
   always_comb begin
      if_rvalid_o  = (state_q == ST_WAIT) && mem_rvalid_i && !owner_q;
      lsu_rvalid_o = (state_q == ST_WAIT) && mem_rvalid_i && owner_q;
      if_rdata_o   = mem_rdata_i;
      lsu_rdata_o  = mem_rdata_i;
      mem_req_o    = (state_q == ST_REQ);
      mem_we_o     = we_q;
      mem_be_o     = be_q;
      mem_addr_o   = addr_q;
      mem_wdata_o  = wdata_q;
      arb_busy_o   = (state_q != ST_IDLE);
      arb_owner_o  = owner_q;
   end

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Randomized scoreboard bench for beta_mem_arbiter: a transaction-level model
// predicts grants, bus contents and responses; a negedge monitor compares.
module tb_beta_mem_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned BW   = DW / 8;
   localparam int          MAXS = 4;
   localparam int          NCYC = 2000;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          lsu_req_i;
   logic          lsu_we_i;
   logic [BW-1:0] lsu_be_i;
   logic [AW-1:0] lsu_addr_i;
   logic [DW-1:0] lsu_wdata_i;
   logic          lsu_gnt_o;
   logic          lsu_rvalid_o;
   logic [DW-1:0] lsu_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [BW-1:0] mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i;
   logic          mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;
   logic          arb_busy_o;
   logic          arb_owner_o;

   beta_mem_arbiter #(
      .AddrWidth (AW),
      .DataWidth (DW),
      .MaxStarve (MAXS)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .lsu_req_i    (lsu_req_i),
      .lsu_we_i     (lsu_we_i),
      .lsu_be_i     (lsu_be_i),
      .lsu_addr_i   (lsu_addr_i),
      .lsu_wdata_i  (lsu_wdata_i),
      .lsu_gnt_o    (lsu_gnt_o),
      .lsu_rvalid_o (lsu_rvalid_o),
      .lsu_rdata_o  (lsu_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .arb_busy_o   (arb_busy_o),
      .arb_owner_o  (arb_owner_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          we;
      logic [BW-1:0] be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct {
      logic          owner;
      logic [DW-1:0] data;
   } rsp_t;

   txn_t q_mem[$];
   rsp_t q_rsp[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Per-cycle expectations, written after the active edge, read on the falling edge.
   logic exp_rst, exp_if_gnt, exp_lsu_gnt, exp_mem_req, exp_busy, exp_owner;
   logic exp_if_rv, exp_lsu_rv;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   initial begin : driver
      int          ph;
      int          gcnt;
      int          wcnt;
      int          starve;
      int          rst_cnt;
      int          pf;
      int          pl;
      logic        owner;
      logic        lsu_wins;
      bit          late_rv;
      bit          mid_rst_done;
      bit          f_pend;
      bit          l_pend;
      logic [AW-1:0] f_addr;
      logic          l_we;
      logic [BW-1:0] l_be;
      logic [AW-1:0] l_addr;
      logic [DW-1:0] l_wdata;
      txn_t          t;
      rsp_t          r;

      ph = 0; gcnt = 0; wcnt = 0; starve = 0; rst_cnt = 3; owner = 1'b0;
      late_rv = 0; mid_rst_done = 0; f_pend = 0; l_pend = 0;
      f_addr = '0; l_we = 1'b0; l_be = '0; l_addr = '0; l_wdata = '0;
      rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      exp_rst = 1'b1; exp_if_gnt = 1'b0; exp_lsu_gnt = 1'b0; exp_mem_req = 1'b0;
      exp_busy = 1'b0; exp_owner = 1'b0; exp_if_rv = 1'b0; exp_lsu_rv = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk_i);
         #1;
         // One reset mid-transaction, while a response is still owed.
         if (!mid_rst_done && cyc > 900 && ph == 2 && rst_cnt == 0) begin
            rst_cnt      = 2;
            mid_rst_done = 1;
         end
         if (rst_cnt > 0) begin
            rst_i   = 1'b1;
            rst_cnt--;
            late_rv = mid_rst_done;
         end else begin
            rst_i = 1'b0;
         end

         // Saturated traffic first to exercise starvation, then sparse, then drain.
         pf = (cyc < 400) ? 100 : (cyc < NCYC - 80) ? 45 : 0;
         pl = (cyc < 400) ? 100 : (cyc < NCYC - 80) ? 55 : 0;
         if (f_pend && cyc >= 400 && $urandom_range(99) < 3) f_pend = 0;
         if (l_pend && cyc >= 400 && $urandom_range(99) < 3) l_pend = 0;
         if (!f_pend && $urandom_range(99) < pf) begin
            f_pend = 1;
            f_addr = $urandom;
         end
         if (!l_pend && $urandom_range(99) < pl) begin
            l_pend  = 1;
            l_we    = 1'($urandom_range(1));
            l_be    = BW'($urandom_range(15));
            l_addr  = $urandom;
            l_wdata = $urandom;
         end
         if_req_i    = f_pend;
         if_addr_i   = f_addr;
         lsu_req_i   = l_pend;
         lsu_we_i    = l_we;
         lsu_be_i    = l_be;
         lsu_addr_i  = l_addr;
         lsu_wdata_i = l_wdata;
         mem_rdata_i = $urandom;

         if (rst_i) begin
            ph = 0; starve = 0; owner = 1'b0;
            q_mem.delete();
            q_rsp.delete();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            exp_rst = 1'b1; exp_if_gnt = 1'b0; exp_lsu_gnt = 1'b0; exp_mem_req = 1'b0;
            exp_busy = 1'b0; exp_owner = 1'b0; exp_if_rv = 1'b0; exp_lsu_rv = 1'b0;
            continue;
         end

         exp_rst   = 1'b0;
         mem_gnt_i = (ph == 1 && gcnt == 0);
         if (ph == 2) begin
            mem_rvalid_i = (wcnt == 0);
         end else if (late_rv) begin
            mem_rvalid_i = 1'b1;
            late_rv      = 0;
         end else begin
            mem_rvalid_i = ($urandom_range(7) == 0) ||
                           (ph == 1 && gcnt == 0 && $urandom_range(1) == 1);
         end

         exp_mem_req = (ph == 1);
         exp_busy    = (ph != 0);
         exp_owner   = owner;
         exp_if_rv   = (ph == 2 && wcnt == 0 && !owner);
         exp_lsu_rv  = (ph == 2 && wcnt == 0 && owner);
         exp_if_gnt  = 1'b0;
         exp_lsu_gnt = 1'b0;
         if (ph == 2 && wcnt == 0) begin
            r.owner = owner;
            r.data  = mem_rdata_i;
            q_rsp.push_back(r);
         end

         case (ph)
            0: begin
               lsu_wins = l_pend && !(f_pend && starve == MAXS);
               if (lsu_wins) begin
                  exp_lsu_gnt = 1'b1;
                  t.we = l_we; t.be = l_be; t.addr = l_addr; t.wdata = l_wdata;
                  q_mem.push_back(t);
                  starve = f_pend ? starve + 1 : 0;
                  owner  = 1'b1;
                  l_pend = 0;
                  ph     = 1;
                  gcnt   = $urandom_range(5);
               end else if (f_pend) begin
                  exp_if_gnt = 1'b1;
                  t.we = 1'b0; t.be = '1; t.addr = f_addr; t.wdata = '0;
                  q_mem.push_back(t);
                  starve = 0;
                  owner  = 1'b0;
                  f_pend = 0;
                  ph     = 1;
                  gcnt   = $urandom_range(5);
               end
            end
            1: begin
               if (gcnt == 0) begin
                  ph   = 2;
                  wcnt = $urandom_range(3);
               end else begin
                  gcnt--;
               end
            end
            default: begin
               if (wcnt == 0) ph = 0;
               else wcnt--;
            end
         endcase
      end

      @(negedge clk_i);
      #1;
      chk("mem_queue_drained", 64'(q_mem.size()), 64'(0));
      chk("rsp_queue_drained", 64'(q_rsp.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   always @(negedge clk_i) begin : monitor
      txn_t t;
      rsp_t r;
      chk("if_gnt",     64'(if_gnt_o),     64'(exp_if_gnt));
      chk("lsu_gnt",    64'(lsu_gnt_o),    64'(exp_lsu_gnt));
      chk("mem_req",    64'(mem_req_o),    64'(exp_mem_req));
      chk("busy",       64'(arb_busy_o),   64'(exp_busy));
      chk("owner",      64'(arb_owner_o),  64'(exp_owner));
      chk("if_rvalid",  64'(if_rvalid_o),  64'(exp_if_rv));
      chk("lsu_rvalid", 64'(lsu_rvalid_o), 64'(exp_lsu_rv));
      if (exp_rst) begin
         chk("rst_mem_we",    64'(mem_we_o),    64'(0));
         chk("rst_mem_be",    64'(mem_be_o),    64'(0));
         chk("rst_mem_addr",  64'(mem_addr_o),  64'(0));
         chk("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
      end
      if (mem_req_o) begin
         if (q_mem.size() == 0) begin
            chk("mem_req_unexpected", 64'(mem_req_o), 64'(0));
         end else begin
            t = q_mem[0];
            chk("mem_we",    64'(mem_we_o),    64'(t.we));
            chk("mem_be",    64'(mem_be_o),    64'(t.be));
            chk("mem_addr",  64'(mem_addr_o),  64'(t.addr));
            chk("mem_wdata", 64'(mem_wdata_o), 64'(t.wdata));
            if (mem_gnt_i) void'(q_mem.pop_front());
         end
      end
      if (if_rvalid_o || lsu_rvalid_o) begin
         if (q_rsp.size() == 0) begin
            chk("rvalid_unexpected", 64'(if_rvalid_o || lsu_rvalid_o), 64'(0));
         end else begin
            r = q_rsp.pop_front();
            chk("rsp_owner", 64'(lsu_rvalid_o), 64'(r.owner));
            chk("rsp_rdata", 64'(r.owner ? lsu_rdata_o : if_rdata_o), 64'(r.data));
         end
      end
   end

endmodule
